// File: rtl/aes_fifo_loader.sv
// rtl/aes_fifo_loader.sv - pops 16 bytes from a byte FIFO, assembles an AES block and hands it to the core
module aes_fifo_loader (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         flush,
    input  logic         fifo_empty,
    input  logic [7:0]   fifo_data,
    output logic         fifo_rd_en,
    output logic         aes_start,
    output logic [127:0] aes_block,
    input  logic         aes_done,
    output logic         busy,
    output logic [7:0]   blk_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [4:0] issued;
    logic [4:0] captured;
    logic       rd_pend;
    logic       last_capture;
    logic       done_hit;

    always_comb begin
        fifo_rd_en   = (state == LOAD) && !fifo_empty && (issued < 5'd16) && !flush;
        aes_start    = (state == START) && !flush;
        busy         = (state != IDLE);
        last_capture = rd_pend && (captured == 5'd15);
        done_hit     = (state == WAIT) && aes_done;
        next_state   = state;
        case (state)
            IDLE:    if (enable) next_state = LOAD;
            LOAD:    if (last_capture) next_state = START;
            START:   next_state = WAIT;
            WAIT:    if (aes_done) next_state = enable ? LOAD : IDLE;
            default: next_state = IDLE;
        endcase
        if (flush) begin
            next_state = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // rd_pend tracks the FIFO's one-cycle read latency; fifo_rd_en is already low during flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issued    <= 5'd0;
            captured  <= 5'd0;
            rd_pend   <= 1'b0;
            aes_block <= 128'd0;
            blk_count <= 8'd0;
        end else begin
            rd_pend <= fifo_rd_en;
            if (flush) begin
                issued   <= 5'd0;
                captured <= 5'd0;
            end else if (done_hit) begin
                issued    <= 5'd0;
                captured  <= 5'd0;
                blk_count <= blk_count + 8'd1;
            end else begin
                if (fifo_rd_en) issued <= issued + 5'd1;
                if (rd_pend) captured <= captured + 5'd1;
            end
            if (rd_pend && !flush) begin
                aes_block <= {aes_block[119:0], fifo_data};
            end
        end
    end

endmodule

// File: tb/tb_aes_fifo_loader.sv
// tb/tb_aes_fifo_loader.sv - randomized self-checking bench for aes_fifo_loader
module tb_aes_fifo_loader;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         enable = 1'b0;
    logic         flush = 1'b0;
    logic         fifo_empty = 1'b1;
    logic [7:0]   fifo_data = 8'd0;
    logic         aes_done = 1'b0;
    logic         fifo_rd_en;
    logic         aes_start;
    logic [127:0] aes_block;
    logic         busy;
    logic [7:0]   blk_count;

    int total = 0;
    int bad = 0;
    int model_cnt = 0;
    logic hold = 1'b0;
    logic o_rd, o_start, o_busy;
    logic [7:0] fq[$];
    logic [7:0] pops[$];
    logic [127:0] ref_const = 128'h000102030405060708090A0B0C0D0E0F;

    always #5 clk = ~clk;

    aes_fifo_loader dut (
        .clk(clk), .rst(rst), .enable(enable), .flush(flush),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en),
        .aes_start(aes_start), .aes_block(aes_block), .aes_done(aes_done),
        .busy(busy), .blk_count(blk_count)
    );

    // One clock cycle: inputs settle after the falling edge, outputs are sampled, the FIFO model
    // pops on the rising edge and presents the byte during the following cycle.
    task automatic cyc();
        logic [7:0] nb;
        logic p;
        nb = 8'd0;
        fifo_empty = hold || (fq.size() == 0);
        #1;
        p = fifo_rd_en;
        o_rd = fifo_rd_en;
        o_start = aes_start;
        o_busy = busy;
        if (p) begin
            nb = fq.pop_front();
            pops.push_back(nb);
        end
        @(posedge clk);
        #1;
        if (p) fifo_data = nb;
        @(negedge clk);
    endtask

    function automatic logic [127:0] exp_block();
        logic [127:0] b;
        b = '0;
        for (int i = 0; i < 16 && i < pops.size(); i++) b[127 - 8*i -: 8] = pops[i];
        return b;
    endfunction

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++) fq.push_back(8'($urandom));
    endtask

    task automatic push_seq();
        for (int i = 0; i < 16; i++) fq.push_back(8'(i));
    endtask

    task automatic run_load(input int hold_after, input int hold_len, output int lat,
                            output int nrd, output int maxrun, output int rd_in_hold,
                            output logic to);
        int run;
        int hleft;
        lat = 0; nrd = 0; maxrun = 0; rd_in_hold = 0; to = 1'b1; run = 0; hleft = hold_len;
        for (int c = 0; c < 200; c++) begin
            hold = (pops.size() == hold_after) && (hleft > 0);
            if (hold) hleft--;
            cyc();
            if (hold && o_rd) rd_in_hold++;
            hold = 1'b0;
            if (o_rd) begin nrd++; run++; end else run = 0;
            if (run > maxrun) maxrun = run;
            if (o_start) begin to = 1'b0; break; end
            if (o_busy) lat++;
        end
    endtask

    task automatic do_done();
        aes_done = 1'b1;
        cyc();
        aes_done = 1'b0;
        model_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        enable = 1'b1;
        cyc();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%0b want=0", fifo_rd_en); end
        total++; if (aes_start !== 1'b0) begin bad++; $display("FAIL reset_start got=%0b want=0", aes_start); end
        total++; if (aes_block !== 128'd0) begin bad++; $display("FAIL reset_block got=%0h want=0", aes_block); end
        total++; if (blk_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", blk_count); end
        enable = 1'b0;
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_basic();
        int lat, nrd, mr, rh;
        logic to;
        pops.delete();
        push_seq();
        enable = 1'b1;
        run_load(-1, 0, lat, nrd, mr, rh, to);
        enable = 1'b0;
        total++; if (to !== 1'b0) begin bad++; $display("FAIL basic_timeout got=%0b want=0", to); end
        total++; if (lat != 17) begin bad++; $display("FAIL basic_latency got=%0d want=17", lat); end
        total++; if (mr != 16 || nrd != 16) begin bad++; $display("FAIL basic_rd_run got=%0d/%0d want=16/16", mr, nrd); end
        total++; if (aes_block !== ref_const) begin bad++; $display("FAIL basic_block got=%0h want=%0h", aes_block, ref_const); end
        cyc();
        total++; if (o_start !== 1'b0 || o_busy !== 1'b1) begin bad++; $display("FAIL basic_wait got=%0b%0b want=01", o_start, o_busy); end
        total++; if (aes_block !== ref_const) begin bad++; $display("FAIL basic_hold got=%0h want=%0h", aes_block, ref_const); end
        do_done();
        total++; if (blk_count !== 8'(model_cnt)) begin bad++; $display("FAIL basic_count got=%0d want=%0d", blk_count, model_cnt); end
        cyc();
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL basic_idle got=%0b want=0", o_busy); end
    endtask

    task automatic test_stall();
        int lat, nrd, mr, rh;
        logic to;
        pops.delete();
        push_seq();
        enable = 1'b1;
        run_load(8, 5, lat, nrd, mr, rh, to);
        enable = 1'b0;
        total++; if (to !== 1'b0 || lat != 22) begin bad++; $display("FAIL stall_latency got=%0d want=22", lat); end
        total++; if (rh != 0 || nrd != 16) begin bad++; $display("FAIL stall_rd got=%0d/%0d want=0/16", rh, nrd); end
        total++; if (aes_block !== ref_const) begin bad++; $display("FAIL stall_block got=%0h want=%0h", aes_block, ref_const); end
        cyc();
        do_done();
        cyc();
    endtask

    task automatic test_done_ignored();
        int lat, nrd, mr, rh;
        logic to;
        pops.delete();
        push_rand(16);
        enable = 1'b1;
        cyc();
        enable = 1'b0;
        aes_done = 1'b1;
        cyc();
        cyc();
        aes_done = 1'b0;
        run_load(-1, 0, lat, nrd, mr, rh, to);
        total++; if (to !== 1'b0 || blk_count !== 8'(model_cnt)) begin bad++; $display("FAIL ignore_count got=%0d want=%0d", blk_count, model_cnt); end
        total++; if (aes_block !== exp_block()) begin bad++; $display("FAIL ignore_block got=%0h want=%0h", aes_block, exp_block()); end
        cyc();
        do_done();
        total++; if (blk_count !== 8'(model_cnt)) begin bad++; $display("FAIL ignore_wait_count got=%0d want=%0d", blk_count, model_cnt); end
        cyc();
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL ignore_idle got=%0b want=0", o_busy); end
    endtask

    task automatic test_flush();
        int lat, nrd, mr, rh;
        logic to;
        logic [7:0] keep;
        pops.delete();
        push_rand(30);
        enable = 1'b1;
        for (int c = 0; c < 40 && pops.size() < 9; c++) cyc();
        keep = blk_count;
        flush = 1'b1;
        enable = 1'b0;
        cyc();
        flush = 1'b0;
        total++; if (o_rd !== 1'b0 || pops.size() != 9) begin bad++; $display("FAIL flush_rd got=%0b/%0d want=0/9", o_rd, pops.size()); end
        cyc();
        total++; if (o_busy !== 1'b0 || blk_count !== keep) begin bad++; $display("FAIL flush_idle got=%0b/%0d want=0/%0d", o_busy, blk_count, keep); end
        pops.delete();
        enable = 1'b1;
        run_load(-1, 0, lat, nrd, mr, rh, to);
        enable = 1'b0;
        total++; if (to !== 1'b0 || lat != 17 || nrd != 16) begin bad++; $display("FAIL flush_reload got=%0d/%0d want=17/16", lat, nrd); end
        total++; if (aes_block !== exp_block()) begin bad++; $display("FAIL flush_block got=%0h want=%0h", aes_block, exp_block()); end
        cyc();
        do_done();
        cyc();
        fq.delete();
    endtask

    task automatic test_reset_mid();
        int lat, nrd, mr, rh, cnt_rd, cnt_busy;
        logic to;
        pops.delete();
        push_rand(16);
        enable = 1'b1;
        for (int c = 0; c < 40 && pops.size() < 5; c++) cyc();
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        total++; if ({fifo_rd_en, aes_start, busy} !== 3'b000) begin bad++; $display("FAIL rstmid_ctrl got=%0b want=000", {fifo_rd_en, aes_start, busy}); end
        total++; if (aes_block !== 128'd0 || blk_count !== 8'd0) begin bad++; $display("FAIL rstmid_regs got=%0h/%0d want=0/0", aes_block, blk_count); end
        model_cnt = 0;
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cnt_rd = 0; cnt_busy = 0;
        for (int c = 0; c < 5; c++) begin
            cyc();
            if (o_rd) cnt_rd++;
            if (o_busy) cnt_busy++;
        end
        total++; if (cnt_rd != 0 || cnt_busy != 0) begin bad++; $display("FAIL rstmid_idle got=%0d/%0d want=0/0", cnt_rd, cnt_busy); end
        fq.delete();
        pops.delete();
        push_rand(16);
        enable = 1'b1;
        run_load(-1, 0, lat, nrd, mr, rh, to);
        enable = 1'b0;
        total++; if (to !== 1'b0 || lat != 17 || aes_block !== exp_block()) begin bad++; $display("FAIL rstmid_reload got=%0h want=%0h", aes_block, exp_block()); end
        cyc();
        do_done();
        total++; if (blk_count !== 8'(model_cnt)) begin bad++; $display("FAIL rstmid_count got=%0d want=%0d", blk_count, model_cnt); end
        cyc();
    endtask

    task automatic test_wrap();
        int lat, nrd, mr, rh, n;
        logic to;
        n = 256 - model_cnt;
        for (int b = 0; b < n; b++) begin
            pops.delete();
            push_rand(16);
            enable = 1'b1;
            run_load(-1, 0, lat, nrd, mr, rh, to);
            cyc();
            total++; if (to !== 1'b0 || aes_block !== exp_block()) begin bad++; $display("FAIL wrap_block%0d got=%0h want=%0h", b, aes_block, exp_block()); end
            if (b == n - 1) enable = 1'b0;
            do_done();
        end
        cyc();
        total++; if (blk_count !== 8'(model_cnt % 256) || model_cnt != 256) begin bad++; $display("FAIL wrap_count got=%0d want=%0d", blk_count, model_cnt % 256); end
        total++; if (aes_block !== exp_block() || o_busy !== 1'b0) begin bad++; $display("FAIL wrap_hold got=%0h want=%0h", aes_block, exp_block()); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_done_ignored();
        test_flush();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
